// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared state encoding, tap table and LFSR step for the decrypt sequencer
// Ports: none (package). Provides DEF_PAD_CHAR, N_PTRN, LFSR_PTRN[0..8], state_t, lfsr_step().
package decrypt_pkg;
   localparam logic [7:0] DEF_PAD_CHAR = 8'h20;
   localparam int         N_PTRN       = 9;
   localparam logic [6:0] LFSR_PTRN [N_PTRN] = '{
      7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
   };
   typedef enum logic [3:0] {
      IDLE, SEED_RD, SEED, TRY_RD, TRY_CHK, DEC_INIT, DEC_RD, DEC_WR, DONE
   } state_t;
   // Shift left, feed back the parity of the tapped bits into bit 0.
   function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
      return {s[5:0], ^(s & taps)};
   endfunction
endpackage

// File: rtl/decrypt_ctrl_lfsr7.sv
// lfsr7: 7-bit Fibonacci-style LFSR with synchronous load and step enable
// Ports: clk, rst_n (async, active-low), load/load_val (load wins over step),
//        step (advance one position using taps), taps (feedback mask), state (current value)
module lfsr7
   import decrypt_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [6:0] load_val,
   input  logic       step,
   input  logic [6:0] taps,
   output logic [6:0] state
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= '0;
      else if (load) state <= load_val;
      else if (step) state <= lfsr_step(state, taps);
   end
endmodule

// File: rtl/decrypt_ctrl.sv
// decrypt_ctrl: ROM-less sequencer that decrypts a parity-tagged LFSR message in data memory
// Ports: Clk, Reset (async active-low), Start (high holds idle; first low after high launches),
//        Ack (run complete, held until Start rises), mem_addr/mem_rd_en/mem_rdata (DM read, data
//        returns next cycle), mem_wr_en/mem_wdata (DM write), pattern_idx (tap index found),
//        fail (no tap pattern matched the preamble), parity_err_cnt (parity-failing bytes).
// Optional: define DECRYPT_PARITY_CHECK_EN to count parity errors; otherwise parity_err_cnt is 0.
module decrypt_ctrl
   import decrypt_pkg::*;
#(
   parameter int         MSG_LEN    = 64,
   parameter int         CRYPT_BASE = 64,
   parameter int         PLAIN_BASE = 0,
   parameter int         PRE_CHECK  = 10,
   parameter logic [7:0] PAD_CHAR   = DEF_PAD_CHAR
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] mem_addr,
   output logic       mem_rd_en,
   input  logic [7:0] mem_rdata,
   output logic       mem_wr_en,
   output logic [7:0] mem_wdata,
   output logic [3:0] pattern_idx,
   output logic       fail,
   output logic [6:0] parity_err_cnt
);
   localparam logic [7:0] CB     = 8'(CRYPT_BASE);
   localparam logic [7:0] PB     = 8'(PLAIN_BASE);
   localparam logic [3:0] I_LAST = 4'(PRE_CHECK - 1);
   localparam logic [6:0] J_LAST = 7'(MSG_LEN - 1);
   localparam logic [3:0] K_LAST = 4'(N_PTRN - 1);

   state_t     state;
   logic       start_seen;
   logic [6:0] seed, s, load_val;
   logic [3:0] k, i;
   logic [6:0] j;
   logic       match, load, step;

   // One LFSR serves both the pattern search and the decrypt pass; it is reloaded from the
   // seed for every new candidate and again before decrypting.
   lfsr7 u_lfsr (
      .clk     (Clk),
      .rst_n   (Reset),
      .load    (load),
      .load_val(load_val),
      .step    (step),
      .taps    (LFSR_PTRN[k]),
      .state   (s)
   );

   // Memory strobes are decoded from the state so a read issued in *_RD lines up with the
   // data consumed in the following state, and reset drops them immediately.
   always_comb begin
      match     = (mem_rdata[6:0] ^ s) == PAD_CHAR[6:0];
      load      = state == SEED || state == DEC_INIT || (state == TRY_CHK && !match && k != K_LAST);
      load_val  = state == SEED ? mem_rdata[6:0] ^ PAD_CHAR[6:0] : seed;
      step      = state == TRY_RD || state == DEC_WR;
      mem_rd_en = state == SEED_RD || state == TRY_RD || state == DEC_RD;
      mem_wr_en = state == DEC_WR;
      mem_addr  = state == SEED_RD ? CB :
                  state == TRY_RD  ? CB + 8'(i) :
                  state == DEC_RD  ? CB + 8'(j) :
                  state == DEC_WR  ? PB + 8'(j) : '0;
      mem_wdata = mem_wr_en ? {1'b0, mem_rdata[6:0] ^ s} : '0;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         start_seen  <= 1'b0;
         Ack         <= 1'b0;
         fail        <= 1'b0;
         pattern_idx <= '0;
         seed        <= '0;
         k           <= '0;
         i           <= '0;
         j           <= '0;
      end else begin
         case (state)
            IDLE:
               if (Start) begin
                  Ack        <= 1'b0;
                  fail       <= 1'b0;
                  start_seen <= 1'b1;
               end else if (start_seen) begin
                  start_seen <= 1'b0;
                  state      <= SEED_RD;
               end
            SEED_RD: state <= SEED;
            SEED: begin
               seed  <= mem_rdata[6:0] ^ PAD_CHAR[6:0];
               k     <= '0;
               i     <= 4'd1;
               state <= TRY_RD;
            end
            TRY_RD: state <= TRY_CHK;
            TRY_CHK:
               if (match) begin
                  if (i == I_LAST) state <= DEC_INIT;
                  else begin
                     i     <= i + 4'd1;
                     state <= TRY_RD;
                  end
               end else if (k != K_LAST) begin
                  k     <= k + 4'd1;
                  i     <= 4'd1;
                  state <= TRY_RD;
               end else begin
                  fail        <= 1'b1;
                  Ack         <= 1'b1;
                  pattern_idx <= k;
                  state       <= DONE;
               end
            DEC_INIT: begin
               j     <= '0;
               state <= DEC_RD;
            end
            DEC_RD: state <= DEC_WR;
            DEC_WR: begin
               j <= j + 7'd1;
               if (j == J_LAST) begin
                  Ack         <= 1'b1;
                  pattern_idx <= k;
                  state       <= DONE;
               end else state <= DEC_RD;
            end
            DONE:
               if (Start) begin
                  Ack        <= 1'b0;
                  fail       <= 1'b0;
                  start_seen <= 1'b1;
                  state      <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DECRYPT_PARITY_CHECK_EN
   // Even parity over the 7 data bits is expected in bit 7; the count saturates at 127.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) parity_err_cnt <= '0;
      else if (state == IDLE && !Start && start_seen) parity_err_cnt <= '0;
      else if (state == DEC_WR && mem_rdata[7] != ^mem_rdata[6:0] && parity_err_cnt != 7'h7F)
         parity_err_cnt <= parity_err_cnt + 7'd1;
   end
`else
   logic rdata_msb_unused;
   assign rdata_msb_unused = mem_rdata[7];
   assign parity_err_cnt   = '0;
`endif
endmodule

// File: doc/decrypt_ctrl.md
Name: decrypt_ctrl

Overview:
Hardware sequencer that runs message decryption (Program #2) directly against the shared data memory, with no instruction ROM involved.
- Reads 64 parity-tagged encrypted bytes from DM[64..127].
- Recovers the LFSR seed and the tap pattern (one of 9 candidates) from the known space-character preamble.
- Writes the decrypted bytes to DM[0..63], then raises Ack.
- Drop-in alternative to the top_level program sequencer: same Start/Ack contract, sole master of the DM port while running.

Parameters:
MSG_LEN, 64, number of bytes to decrypt (1..64)
CRYPT_BASE, 64, DM address of encrypted byte 0
PLAIN_BASE, 0, DM address of decrypted byte 0
PRE_CHECK, 10, leading bytes checked against PAD_CHAR during pattern search (2..15)
PAD_CHAR, 8'h20, preamble character (ASCII space)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  high holds the block idle; the first low cycle after a high cycle launches a run
Ack  out  1  run complete; held until Start next rises
mem_addr  out  8  DM address
mem_rd_en  out  1  DM read strobe; data returns on mem_rdata the next cycle
mem_rdata  in  8  DM read data
mem_wr_en  out  1  DM write strobe, committed on the rising edge
mem_wdata  out  8  DM write data
pattern_idx  out  4  index (0..8) of the tap pattern found
fail  out  1  no candidate pattern matched the preamble
parity_err_cnt  out  7  count of parity-failing bytes (optional feature)

Behaviour:
- Reset (Reset=0, async): state IDLE; all outputs 0; internal registers cleared. Reset mid-run aborts immediately; no further writes occur.
- LFSR step: next = {s[5:0], ^(s & taps)}.
- Tap table LFSR_PTRN[0..8] = 60,48,78,72,6A,69,5C,7E,7B (hex).
- States:
  - IDLE: Start=1 clears Ack and fail, sets start_seen. Start=0 with start_seen goes to SEED_RD and clears start_seen.
  - SEED_RD: rd addr CRYPT_BASE.
  - SEED: seed = mem_rdata[6:0] ^ PAD_CHAR[6:0]; k=0; s=seed; i=1; go to TRY_RD.
  - TRY_RD: s=step(s, LFSR_PTRN[k]); rd addr CRYPT_BASE+i.
  - TRY_CHK: compare mem_rdata[6:0]^s against PAD_CHAR[6:0].
    - Match and i=PRE_CHECK-1: go to DEC_INIT.
    - Match otherwise: i++, go to TRY_RD.
    - Mismatch and k<8: k++, s=seed, i=1, go to TRY_RD.
    - Mismatch and k=8: fail=1, go to DONE.
  - DEC_INIT: s=seed; j=0.
  - DEC_RD: rd addr CRYPT_BASE+j.
  - DEC_WR: wr addr PLAIN_BASE+j; wdata = {1'b0, mem_rdata[6:0]^s}; s=step; j++.
    - j=MSG_LEN-1 (before increment): go to DONE.
    - Otherwise: go to DEC_RD.
  - DONE: Ack=1, pattern_idx=k; stay until Start=1, then go to IDLE.
- Bit 7 of each encrypted byte is ignored for decryption.
- Read and write strobes are never active in the same cycle; mem_addr is don't-care when neither strobe is active.
- On fail: zero writes issued; DM[0..63] left unchanged.
- First matching k wins, so the lowest index has priority on ambiguity.
- Latency, Start-low to Ack: ≤ 3 + 2·9·(PRE_CHECK−1) + 2·MSG_LEN + 2. With defaults this is ≤ 295 cycles.
- Start rising mid-run is ignored; the run completes. Start=1 at DONE clears Ack on the next edge.

Optional Feature:
DECRYPT_PARITY_CHECK_EN
- Defined: in DEC_WR, if mem_rdata[7] != ^mem_rdata[6:0], parity_err_cnt increments (saturates at 127). The counter clears when a run launches. Decrypted data is still written.
- Undefined: parity_err_cnt is tied to 0 and no parity logic is synthesised.

Decomposition:
- Package decrypt_pkg:
  - LFSR_PTRN[9] constant table
  - state_t enum
  - lfsr_step(s, taps) function
  - default PAD_CHAR
- Sub-module lfsr7:
  - inputs: load, load_val, step, taps
  - output: 7-bit state
  - used for both the search and decrypt LFSR.

Test Plan:
- Pattern 0x60, init 0x01, pre_length 10, message "Mr. Watson, come here. I want to see you." -> DM[0..9]=0x20, DM[10]=0x4D, DM[11]=0x72, all 64 bytes match; pattern_idx=0, fail=0, Ack within 295 cycles.
- Pattern 0x7B, init 0x55, pre_length 15, message " Knowledge comes, but wisdom lingers." -> pattern_idx=8; all 64 bytes match.
- DM[65] altered so byte 1 fails under every pattern -> fail=1, Ack=1, mem_wr_en never asserted, DM[0..63] unchanged.
- Reset pulsed low at cycle 150 of a run -> Ack=0, strobes 0 immediately; a fresh Start high-then-low pass then completes with full score.
- With DECRYPT_PARITY_CHECK_EN, bit 7 of DM[70] and DM[100] flipped -> parity_err_cnt=2 and decrypted output still fully correct. Without the macro, parity_err_cnt=0.
- Start held high 5 cycles after Ack -> Ack drops 1 cycle after Start rises; a second launch with the same data repeats identical results.
